// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Package  : keccak_pkg
// Purpose  : Shared constants and types for the Keccak state I/O stage.
//            Lane geometry (LANES, W, AW), the lane index type and the
//            state encoding of the load/drain sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int LANES = 25;   // 5x5 lanes in the state
    localparam int W     = 64;   // lane width in bits
    localparam int AW    = 5;    // lane address width, 2^AW >= LANES

    typedef logic [AW-1:0] lane_idx_t;

    // Sequencer state encoding
    localparam logic [2:0] LOAD  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] RADDR = 3'd3;
    localparam logic [2:0] RCAP  = 3'd4;
    localparam logic [2:0] OUT   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/keccak_lane_counter.sv
`default_nettype none
// ============================================================================
// Module   : keccak_lane_counter
// Purpose  : Lane index counter. Increments on en, returns to zero on clr
//            (clr wins), and flags the last lane index LANES-1.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            en            - advance to the next lane
//            clr           - return to lane 0
//            count [AW]    - current lane index
//            terminal      - count == LANES-1
// Revision : 1.0 - initial release
// ============================================================================
module keccak_lane_counter #(
    parameter int LANES = keccak_pkg::LANES,
    parameter int AW    = keccak_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [AW-1:0] count,
    output logic          terminal
);

    localparam logic [AW-1:0] c_lastIdx = AW'(LANES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + AW'(1);
        end
    end

    assign terminal = (count == c_lastIdx);

endmodule
`default_nettype wire

// File: rtl/keccak_state_io.sv
`default_nettype none
// ============================================================================
// Module   : keccak_state_io
// Purpose  : I/O stage around the Keccak permutation core. Streams 25 input
//            lanes into the shared lane memory, starts the core, waits for
//            it to finish, then reads the lanes back and streams them out.
// Ports    : clk, rst                  - clock, asynchronous active-high reset
//            in_valid/in_lane/in_ready - input lane stream
//            mem_sel                   - 1 = this block owns the lane memory
//            mem_we/mem_addr/mem_wdata - lane memory write/address port
//            mem_rdata                 - lane memory read data (1-cycle latency)
//            core_start/core_done      - permutation core handshake
//            out_valid/out_lane/out_last/out_ready - output lane stream
//            busy                      - high unless idle in LOAD at lane 0
// Revision : 1.0 - initial release
// ============================================================================
module keccak_state_io #(
    parameter int LANES = keccak_pkg::LANES,
    parameter int W     = keccak_pkg::W,
    parameter int AW    = keccak_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_lane,
    output logic          in_ready,
    output logic          mem_sel,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wdata,
    input  logic [W-1:0]  mem_rdata,
    output logic          core_start,
    input  logic          core_done,
    output logic          out_valid,
    output logic [W-1:0]  out_lane,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy
);

    import keccak_pkg::*;

    logic [2:0]    r_state;
    logic [AW-1:0] w_idx;
    logic          w_idxLast;
    logic          w_loadBeat;
    logic          w_outBeat;
    logic          w_advance;
    logic          w_coreOwns;

    // The index advances on every accepted input lane and on every output
    // handshake; at the last lane it folds back to zero for the next phase.
    assign w_loadBeat = (r_state == LOAD) && in_valid;
    assign w_outBeat  = (r_state == OUT) && out_ready;
    assign w_advance  = w_loadBeat || w_outBeat;

    keccak_lane_counter #(
        .LANES (LANES),
        .AW    (AW)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .en       (w_advance),
        .clr      (w_advance && w_idxLast),
        .count    (w_idx),
        .terminal (w_idxLast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= LOAD;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid && w_idxLast) begin
                        r_state <= START;
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        r_state <= RADDR;
                    end
                end
                RADDR: begin
                    r_state <= RCAP;
                end
                RCAP: begin
                    // Read data for the address issued in RADDR is valid now.
                    out_lane  <= mem_rdata;
                    out_valid <= 1'b1;
                    out_last  <= w_idxLast;
                    r_state   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        r_state   <= w_idxLast ? LOAD : RADDR;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    // The core owns the memory from the start pulse until it reports done.
    assign w_coreOwns = (r_state == START) || (r_state == WAIT);

    assign in_ready   = (r_state == LOAD);
    assign mem_sel    = !w_coreOwns;
    assign mem_we     = w_loadBeat;
    assign mem_addr   = w_coreOwns ? '0 : w_idx;
    assign mem_wdata  = w_loadBeat ? in_lane : '0;
    assign core_start = (r_state == START);
    assign busy       = !((r_state == LOAD) && (w_idx == '0));

endmodule
`default_nettype wire

// File: doc/keccak_state_io.md
Name: keccak_state_io

Overview:
- Upstream/downstream I/O stage for the Keccak permutation controller.
- Accepts the 25 input lanes over a valid/ready stream and writes them into the shared lane memory, then pulses core_start to the permutation controller.
- Waits for core_done, then reads the 25 result lanes back out of the same memory and streams them out over valid/ready.
- Owns the lane memory port only while loading or draining; the core owns it otherwise.

Parameters:
- LANES, 25, number of lanes in the state (5x5).
- W, 64, lane width in bits.
- AW, 5, lane address width; must satisfy 2^AW >= LANES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input lane valid.
- in_lane  in  W  input lane data; lane index = x+5y, sent in ascending index order.
- in_ready  out  1  block accepts in_lane this cycle.
- mem_sel  out  1  1 = this block drives the lane memory; 0 = the core drives it.
- mem_we  out  1  lane memory write enable.
- mem_addr  out  AW  lane memory address.
- mem_wdata  out  W  lane memory write data.
- mem_rdata  in  W  lane memory read data; synchronous read, valid 1 cycle after the address.
- core_start  out  1  one-cycle pulse that starts the permutation.
- core_done  in  1  permutation finished; level or pulse, sampled only in WAIT.
- out_valid  out  1  output lane valid.
- out_lane  out  W  output lane data, ascending index order.
- out_last  out  1  high with the lane at index LANES-1.
- out_ready  in  1  downstream accepts out_lane.
- busy  out  1  high in every state except LOAD with idx==0.

Behaviour:
- Reset:
  - State LOAD, idx=0.
  - All outputs 0 except in_ready=1 and mem_sel=1.
  - out_lane=0.
- Reset mid-operation: abort immediately with the same values. No partial state is retained and no core_start is issued.
- FSM states: LOAD, START, WAIT, RADDR, RCAP, OUT.
- LOAD:
  - in_ready=1, mem_sel=1.
  - On in_valid: mem_we=1 combinationally, mem_addr=idx, mem_wdata=in_lane.
  - If idx==LANES-1: idx<=0 and go to START. Otherwise idx<=idx+1.
  - No in_valid: hold.
- START:
  - core_start=1 for exactly one cycle. mem_sel=0, in_ready=0.
  - Next state WAIT.
- WAIT:
  - mem_sel=0.
  - When core_done=1, go to RADDR.
  - core_done in any other state is ignored.
- RADDR:
  - mem_sel=1, mem_addr=idx, mem_we=0.
  - Next state RCAP.
- RCAP:
  - out_lane<=mem_rdata (registered), out_valid<=1, out_last<=(idx==LANES-1).
  - Next state OUT.
- OUT:
  - out_valid, out_lane and out_last stay stable until out_ready=1.
  - On the handshake: out_valid<=0.
  - If idx==LANES-1: idx<=0 and go to LOAD. Otherwise idx<=idx+1 and go to RADDR.
- Throughput:
  - Load: 1 lane/cycle.
  - Drain: 1 lane per 3 cycles when out_ready is held high.
- Latency from the 25th input handshake:
  - core_start is high on the next cycle.
  - First out_valid is 2 cycles after core_done is sampled.
- Counter: idx is AW bits and wraps only via the explicit reset-to-0 at LANES-1. Values >= LANES are unreachable.
- in_valid while not in LOAD: ignored, no write (in_ready=0).
- out_ready=1 while out_valid=0: ignored.
- mem_we is 1 only in LOAD with in_valid=1.
- mem_addr=0 when mem_sel=0.

Decomposition:
- Shared package keccak_pkg:
  - LANES, W and AW constants.
  - State encoding constants for this FSM: 3-bit localparams LOAD=0, START=1, WAIT=2, RADDR=3, RCAP=4, OUT=5.
  - lane_idx_t (AW bits).
- One sub-module, keccak_lane_counter: AW-bit counter with en, clr and terminal flag at LANES-1. It is used for idx.
- The FSM and output register stay in keccak_state_io.

Test Plan:
- Load 25 lanes with values 0x1000+i, in_valid held high, i=0..24 -> mem_we high 25 consecutive cycles at addr 0..24 with matching data; core_start pulses exactly once, on the cycle after the last write; in_ready=0 afterwards.
- Memory model returns lane i = ~(0x1000+i) with 1-cycle latency; core_done pulses 10 cycles after start; out_ready held high -> 25 lanes out in order 0..24 matching the model, one every 3 cycles, out_last only on lane 24, state returns to LOAD with busy=0.
- Random out_ready backpressure (~50%) -> out_lane and out_valid stay unchanged while stalled, no lane is lost or duplicated, 25 handshakes total.
- Gaps in in_valid, plus in_valid=1 during WAIT with 0xDEAD -> only the 25 loaded lanes are written; no mem_we and no second core_start during WAIT.
- core_done asserted during LOAD, then held high continuously -> ignored in LOAD; drain starts only after START->WAIT; exactly one drain pass occurs.
- rst asserted at idx=12 of the load and again at lane 7 of the drain -> all outputs return to reset values immediately; the next full 25-lane load behaves as in the first scenario.
